// File: rtl/gate_unit_arbiter.sv
// rtl/gate_unit_arbiter.sv - round-robin arbiter sharing one two-stage NAND evaluation unit
module gate_unit_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   A,
    input  logic [N*W-1:0]   B,
    input  logic [2*N-1:0]   op,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_id,
    output logic [W-1:0]     Z
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, STAGE1, STAGE2} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_sel;
    logic [IW-1:0] w_sel;
    logic [IW-1:0] w_ptr_next;
    logic          w_grant;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [1:0]    r_op;
    logic [W-1:0]  r_t1;
    logic [W-1:0]  r_z;
    logic          r_done;
    logic [1:0]    r_done_id;
    logic [W-1:0]  w_a_eff;
    logic [W-1:0]  w_b_eff;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_sel = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % N]) begin
                w_sel = IW'((int'(r_ptr) + k) % N);
            end
        end
        w_ptr_next = IW'((int'(w_sel) + 1) % N);
    end

    // A done cycle is already IDLE, so a fresh grant may overlap it.
    assign w_grant = (r_state == IDLE) && (|req) && !rst;

    always_comb begin
        gnt = '0;
        if (w_grant) begin
            gnt[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_next = STAGE1;
            STAGE1:  w_next = STAGE2;
            STAGE2:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_a_eff = r_op[1] ? ~r_a : r_a;
    assign w_b_eff = r_op[1] ? ~r_b : r_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_done    <= 1'b0;
            r_done_id <= 2'd0;
            r_z       <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == STAGE2);
            if (w_grant) begin
                r_a   <= A[w_sel*W +: W];
                r_b   <= B[w_sel*W +: W];
                r_op  <= op[w_sel*2 +: 2];
                r_sel <= w_sel;
                r_ptr <= w_ptr_next;
            end
            if (r_state == STAGE1) begin
                r_t1 <= ~(w_a_eff & w_b_eff);
            end
            if (r_state == STAGE2) begin
                r_z       <= r_op[0] ? ~(r_t1 & r_t1) : r_t1;
                r_done_id <= 2'(r_sel);
            end
        end
    end

    assign busy    = (r_state != IDLE) || r_done;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign Z       = r_z;
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb/tb_gate_unit_arbiter.sv - randomized and directed bench for gate_unit_arbiter
module tb_gate_unit_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] A;
    logic [N*W-1:0] B;
    logic [2*N-1:0] op;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic [1:0]     done_id;
    logic [W-1:0]   Z;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gate_unit_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .A(A), .B(B), .op(op),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .Z(Z)
    );

    // Reference: a job granted in cycle g completes in cycle g+3.
    int         cyc = 0;
    int         m_ptr = 0;
    int         m_gcyc = 0;
    int         m_job_id = 0;
    bit         m_inflight = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_z = '0;
    logic [1:0]   m_id = '0;
    logic [N-1:0] e_gnt;
    logic         e_busy;
    logic         e_done;
    logic [W-1:0] e_z;
    logic [1:0]   e_id;

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] o);
        case (o)
            2'b00:   return ~(a & b);
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic model_step();
        int s;
        e_done = 1'b0;
        e_busy = m_inflight && (cyc > m_gcyc);
        if (m_inflight && cyc == m_gcyc + 3) begin
            e_done     = 1'b1;
            m_z        = m_res;
            m_id       = 2'(m_job_id);
            m_inflight = 1'b0;
        end
        e_z   = m_z;
        e_id  = m_id;
        e_gnt = '0;
        if (!rst && !m_inflight && req != '0) begin
            s = -1;
            for (int k = 0; k < N; k++) begin
                if (s < 0 && req[(m_ptr + k) % N]) s = (m_ptr + k) % N;
            end
            e_gnt[s]   = 1'b1;
            m_res      = ref_op(A[s*W +: W], B[s*W +: W], op[2*s +: 2]);
            m_job_id   = s;
            m_gcyc     = cyc;
            m_inflight = 1'b1;
            m_ptr      = (s + 1) % N;
        end
        if (rst) begin
            m_inflight = 1'b0;
            m_ptr      = 0;
            m_z        = '0;
            m_id       = '0;
        end
        cyc++;
    endtask

    task automatic apply(input logic [N-1:0] rq, input logic r);
        req = rq;
        rst = r;
        model_step();
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply('0, 1'b1);
        tick();
        apply('0, 1'b0);
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (done_id !== 2'd0) begin miscompares++; $display("FAIL reset_done_id got %0d want 0", done_id); end
        vectors++; if (Z !== 8'h00) begin miscompares++; $display("FAIL reset_Z got %h want 00", Z); end
        tick();
    endtask

    task automatic test_single_and();
        A[7:0] = 8'hF0; B[7:0] = 8'h3C; op[1:0] = 2'b01;
        apply(4'b0001, 1'b0);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL and_gnt got %b want 0001", gnt); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            apply('0, 1'b0);
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL and_busy c%0d got %b want 1", i, busy); end
            vectors++; if (done !== (i == 3)) begin miscompares++; $display("FAIL and_done c%0d got %b want %b", i, done, i == 3); end
            tick();
        end
        apply('0, 1'b0);
        vectors++; if (Z !== 8'h30) begin miscompares++; $display("FAIL and_Z got %h want 30", Z); end
        vectors++; if (done_id !== 2'd0) begin miscompares++; $display("FAIL and_done_id got %0d want 0", done_id); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL and_busy_after got %b want 0", busy); end
        tick();
    endtask

    task automatic test_all_ops();
        logic [W-1:0] tab [4];
        tab = '{8'h7D, 8'h82, 8'hEE, 8'h11};
        for (int o = 0; o < 4; o++) begin
            A = {4{8'hCA}}; B = {4{8'hA6}}; op = {4{2'(o)}};
            apply(4'b0010, 1'b0);
            vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL ops%0d_gnt got %b want 0010", o, gnt); end
            tick();
            for (int i = 1; i <= 3; i++) begin
                apply('0, 1'b0);
                if (i == 3) begin
                    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ops%0d_done got %b want 1", o, done); end
                    vectors++; if (Z !== tab[o]) begin miscompares++; $display("FAIL ops%0d_Z got %h want %h", o, Z, tab[o]); end
                    vectors++; if (done_id !== 2'd1) begin miscompares++; $display("FAIL ops%0d_id got %0d want 1", o, done_id); end
                end
                tick();
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        apply(4'b1111, 1'b1);
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rr_gnt_in_reset got %b want 0000", gnt); end
        tick();
        for (int c = 0; c <= 12; c++) begin
            apply(4'b1111, 1'b0);
            want = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            vectors++; if (gnt !== want) begin miscompares++; $display("FAIL rr_gnt c%0d got %b want %b", c, gnt, want); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin apply('0, 1'b0); tick(); end
    endtask

    task automatic test_wrap_skip();
        apply('0, 1'b1);
        tick();
        apply(4'b0100, 1'b0);
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL wrap_first got %b want 0100", gnt); end
        tick();
        for (int i = 0; i < 2; i++) begin apply('0, 1'b0); tick(); end
        apply(4'b0101, 1'b0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %b want 1", done); end
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wrap_to0 got %b want 0001", gnt); end
        tick();
        for (int i = 0; i < 2; i++) begin apply(4'b0101, 1'b0); tick(); end
        apply(4'b0101, 1'b0);
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL wrap_to2 got %b want 0100", gnt); end
        tick();
        for (int i = 0; i < 3; i++) begin apply('0, 1'b0); tick(); end
    endtask

    task automatic test_operand_hold();
        A[7:0] = 8'hCA; B[7:0] = 8'hA6; op[1:0] = 2'b00;
        apply(4'b0001, 1'b0);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL hold_gnt got %b want 0001", gnt); end
        tick();
        A[7:0] = 8'hFF; op[1:0] = 2'b11;
        apply('0, 1'b0); tick();
        apply('0, 1'b0); tick();
        apply('0, 1'b0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL hold_done got %b want 1", done); end
        vectors++; if (Z !== 8'h7D) begin miscompares++; $display("FAIL hold_Z got %h want 7d", Z); end
        tick();
    endtask

    task automatic test_reset_mid_job();
        apply(4'b1000, 1'b0);
        vectors++; if (gnt === 4'b0000) begin miscompares++; $display("FAIL mid_gnt got %b want nonzero", gnt); end
        tick();
        apply('0, 1'b0); tick();
        apply('0, 1'b1); tick();
        for (int i = 0; i < 2; i++) begin
            apply('0, 1'b0);
            vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done c%0d got %b want 0", i, done); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy c%0d got %b want 0", i, busy); end
            vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL mid_gnt0 c%0d got %b want 0000", i, gnt); end
            vectors++; if (Z !== 8'h00) begin miscompares++; $display("FAIL mid_Z c%0d got %h want 00", i, Z); end
            vectors++; if (done_id !== 2'd0) begin miscompares++; $display("FAIL mid_id c%0d got %0d want 0", i, done_id); end
            tick();
        end
        apply(4'b0010, 1'b0);
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL mid_regrant got %b want 0010", gnt); end
        tick();
        for (int i = 0; i < 3; i++) begin apply('0, 1'b0); tick(); end
    endtask

    task automatic test_random();
        logic [N-1:0] rq;
        for (int c = 0; c < 600; c++) begin
            rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            A  = $urandom();
            B  = $urandom();
            op = 8'($urandom());
            apply(rq, $urandom_range(0, 39) == 0);
            vectors++; if (gnt !== e_gnt) begin miscompares++; $display("FAIL rnd_gnt c%0d got %b want %b", c, gnt, e_gnt); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, e_busy); end
            vectors++; if (done !== e_done) begin miscompares++; $display("FAIL rnd_done c%0d got %b want %b", c, done, e_done); end
            vectors++; if (Z !== e_z) begin miscompares++; $display("FAIL rnd_Z c%0d got %h want %h", c, Z, e_z); end
            vectors++; if (done_id !== e_id) begin miscompares++; $display("FAIL rnd_id c%0d got %0d want %0d", c, done_id, e_id); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        A   = '0;
        B   = '0;
        op  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_and();
        test_all_ops();
        test_round_robin();
        test_wrap_skip();
        test_operand_hold();
        test_reset_mid_job();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
